// File: rtl/phy_write_sequencer.sv
// One-at-a-time WRITE burst sequencer: loads BURST_LENGTH contiguous beats into the PHY FIFO, then drives them at issue+CWL.
// Latency: wrDone at CWL+BURST_LENGTH/2 cycles after acceptance; no issue is accepted while busy (wrIssueReady low), and a buffer stall aborts the burst.
module phy_write_sequencer #(
  parameter int BURST_LENGTH = 8,
  parameter int CWL          = 12,
  parameter int ID_W         = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wrIssue,
  input  logic [ID_W-1:0] wrIssueId,
  output logic            wrIssueReady,
  input  logic            bufValid,
  output logic            phyInflag,
  output logic            phyOutflag,
  input  logic            phyOutAck,
  output logic            wrDone,
  output logic [ID_W-1:0] wrDoneId,
  output logic [1:0]      wrErr,
  output logic            busy
);

  localparam int LW = $clog2(CWL + BURST_LENGTH + 1);
  localparam int BW = $clog2(BURST_LENGTH);
  localparam logic [LW-1:0] LAT_LAST_START = LW'(CWL - BURST_LENGTH);
  localparam logic [LW-1:0] LAT_PRE_DRIVE  = LW'(CWL - 1);
  localparam logic [LW-1:0] LAT_DRIVE_END  = LW'(CWL + BURST_LENGTH / 2 - 1);
  localparam logic [BW-1:0] BEAT_LAST      = BW'(BURST_LENGTH - 1);

  if (CWL < BURST_LENGTH + 2) begin : g_cwl_chk
    $error("phy_write_sequencer: CWL must be >= BURST_LENGTH + 2");
  end
  if ((BURST_LENGTH < 4) || ((BURST_LENGTH & (BURST_LENGTH - 1)) != 0)) begin : g_bl_chk
    $error("phy_write_sequencer: BURST_LENGTH must be a power of two >= 4");
  end

  typedef enum logic [2:0] {
    IDLE,
    LOAD_WAIT,
    LOAD,
    WAIT_CWL,
    DRIVE,
    DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [LW-1:0]   r_lat;
  logic [BW-1:0]   r_beat;
  logic [ID_W-1:0] r_id;
  logic            r_ack;
  logic            r_under;
  logic            r_outflag;
  logic            w_inflag;
  logic            w_under;
  logic            w_accept;

  assign w_accept = (r_state == IDLE) && wrIssue;

  always_comb begin
    w_next   = r_state;
    w_inflag = 1'b0;
    w_under  = 1'b0;
    case (r_state)
      IDLE: begin
        if (wrIssue) w_next = LOAD_WAIT;
      end
      LOAD_WAIT: begin
        if (bufValid) begin
          w_inflag = 1'b1;
          w_next   = LOAD;
        end else if (r_lat == LAT_LAST_START) begin
          w_under = 1'b1;
          w_next  = DONE;
        end
      end
      LOAD: begin
        w_inflag = bufValid;
        if (!bufValid) begin
          w_under = 1'b1;
          w_next  = DONE;
        end else if (r_beat == BEAT_LAST) begin
          w_next = (r_lat == LAT_PRE_DRIVE) ? DRIVE : WAIT_CWL;
        end
      end
      WAIT_CWL: begin
        if (r_lat == LAT_PRE_DRIVE) w_next = DRIVE;
      end
      DRIVE: begin
        if (r_lat == LAT_DRIVE_END) w_next = DONE;
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_lat     <= '0;
      r_beat    <= '0;
      r_id      <= '0;
      r_ack     <= 1'b0;
      r_under   <= 1'b0;
      r_outflag <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_outflag <= (w_next == DRIVE);
      if (w_accept) begin
        // Loaded with 1 so latCnt equals the cycle number counted from acceptance.
        r_id    <= wrIssueId;
        r_lat   <= LW'(1);
        r_beat  <= '0;
        r_ack   <= 1'b0;
        r_under <= 1'b0;
      end else begin
        if ((r_state != IDLE) && (r_lat != '1)) r_lat <= r_lat + LW'(1);
        if (w_inflag) r_beat <= r_beat + BW'(1);
        if ((r_state == DRIVE) && phyOutAck) r_ack <= 1'b1;
        if (w_under) r_under <= 1'b1;
      end
    end
  end

  assign wrIssueReady = (r_state == IDLE);
  assign busy         = (r_state != IDLE);
  assign phyInflag    = w_inflag;
  assign phyOutflag   = r_outflag;
  assign wrDone       = (r_state == DONE);
  assign wrDoneId     = (r_state == DONE) ? r_id : '0;

  // The ACK may still arrive in the DONE cycle itself, so it is folded in combinationally.
  always_comb begin
    wrErr = 2'b00;
    if (r_state == DONE) begin
      if (r_under)                     wrErr = 2'b01;
      else if (!(r_ack || phyOutAck))  wrErr = 2'b10;
    end
  end

endmodule

// File: tb/tb_phy_write_sequencer.sv
// Directed bench for phy_write_sequencer: per-cycle traces captured as bit masks, compared to hand-derived masks.
module tb_phy_write_sequencer;

  logic       clk;
  logic       rst;
  logic       wrIssue;
  logic [3:0] wrIssueId;
  logic       wrIssueReady;
  logic       bufValid;
  logic       phyInflag;
  logic       phyOutflag;
  logic       phyOutAck;
  logic       wrDone;
  logic [3:0] wrDoneId;
  logic [1:0] wrErr;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] obs_in, obs_out, obs_done, obs_ready, obs_busy;
  logic [3:0]  seen_id;
  logic [1:0]  seen_err;
  int          ndone;

  phy_write_sequencer #(.BURST_LENGTH(8), .CWL(12), .ID_W(4)) dut (
    .clk(clk), .rst(rst),
    .wrIssue(wrIssue), .wrIssueId(wrIssueId), .wrIssueReady(wrIssueReady),
    .bufValid(bufValid), .phyInflag(phyInflag), .phyOutflag(phyOutflag),
    .phyOutAck(phyOutAck), .wrDone(wrDone), .wrDoneId(wrDoneId),
    .wrErr(wrErr), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle k of a run: inputs driven 1 time unit after the k-th posedge, outputs sampled 2 units later.
  task automatic run(input logic [3:0] id, input logic [31:0] iss, input logic [31:0] bufv,
                     input logic [31:0] ack, input logic [31:0] rstm, input int n);
    obs_in = '0; obs_out = '0; obs_done = '0; obs_ready = '0; obs_busy = '0;
    seen_id = '0; seen_err = '0; ndone = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      rst       = rstm[k];
      wrIssue   = iss[k];
      wrIssueId = (k == 0) ? id : ~id;
      bufValid  = bufv[k];
      phyOutAck = ack[k];
      #2;
      obs_in[k]    = phyInflag;
      obs_out[k]   = phyOutflag;
      obs_done[k]  = wrDone;
      obs_ready[k] = wrIssueReady;
      obs_busy[k]  = busy;
      if (wrDone) begin
        ndone++;
        seen_id  = wrDoneId;
        seen_err = wrErr;
      end
    end
    wrIssue = 1'b0; bufValid = 1'b0; phyOutAck = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; wrIssue = 1'b0; wrIssueId = 4'h0; bufValid = 1'b0; phyOutAck = 1'b0;
    @(posedge clk); #3;
    n_tests++; if (phyInflag !== 1'b0) begin n_fail++; $display("FAIL reset_inflag: got %b want 0", phyInflag); end
    n_tests++; if (phyOutflag !== 1'b0) begin n_fail++; $display("FAIL reset_outflag: got %b want 0", phyOutflag); end
    n_tests++; if ({wrDone, wrDoneId, wrErr} !== 7'd0) begin n_fail++; $display("FAIL reset_done: got %b/%h/%b want 0/0/00", wrDone, wrDoneId, wrErr); end
    @(posedge clk); #1; rst = 1'b0; #2;
    n_tests++; if (wrIssueReady !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", wrIssueReady); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_nominal;
    run(4'd3, 32'h1, 32'hFFFF_FFFF, 32'h0000_8000, 32'h0, 18);
    n_tests++; if (obs_in !== 32'h0000_01FE) begin n_fail++; $display("FAIL nom_inflag: got %h want %h", obs_in, 32'h1FE); end
    n_tests++; if (obs_out !== 32'h0000_F000) begin n_fail++; $display("FAIL nom_outflag: got %h want %h", obs_out, 32'hF000); end
    n_tests++; if (obs_done !== 32'h0001_0000) begin n_fail++; $display("FAIL nom_done: got %h want %h", obs_done, 32'h10000); end
    n_tests++; if (obs_ready !== 32'h0002_0001) begin n_fail++; $display("FAIL nom_ready: got %h want %h", obs_ready, 32'h20001); end
    n_tests++; if (obs_busy !== 32'h0001_FFFE) begin n_fail++; $display("FAIL nom_busy: got %h want %h", obs_busy, 32'h1FFFE); end
    n_tests++; if ({seen_id, seen_err} !== {4'd3, 2'b00}) begin n_fail++; $display("FAIL nom_id_err: got %h/%b want 3/00", seen_id, seen_err); end
  endtask

  task automatic test_late_start;
    run(4'd5, 32'h1, 32'hFFFF_FFF0, 32'h0000_8000, 32'h0, 18);
    n_tests++; if (obs_in !== 32'h0000_0FF0) begin n_fail++; $display("FAIL late_inflag: got %h want %h", obs_in, 32'hFF0); end
    n_tests++; if (obs_out !== 32'h0000_F000) begin n_fail++; $display("FAIL late_outflag: got %h want %h", obs_out, 32'hF000); end
    n_tests++; if (obs_done !== 32'h0001_0000) begin n_fail++; $display("FAIL late_done: got %h want %h", obs_done, 32'h10000); end
    n_tests++; if ({seen_id, seen_err} !== {4'd5, 2'b00}) begin n_fail++; $display("FAIL late_id_err: got %h/%b want 5/00", seen_id, seen_err); end
  endtask

  task automatic test_missed_start;
    run(4'd9, 32'h1, 32'h0, 32'h0, 32'h0, 8);
    n_tests++; if (obs_done !== 32'h0000_0020) begin n_fail++; $display("FAIL miss_done: got %h want %h", obs_done, 32'h20); end
    n_tests++; if (obs_out !== 32'h0) begin n_fail++; $display("FAIL miss_outflag: got %h want 0", obs_out); end
    n_tests++; if (obs_ready !== 32'h0000_00C1) begin n_fail++; $display("FAIL miss_ready: got %h want %h", obs_ready, 32'hC1); end
    n_tests++; if ({seen_id, seen_err} !== {4'd9, 2'b01}) begin n_fail++; $display("FAIL miss_id_err: got %h/%b want 9/01", seen_id, seen_err); end
  endtask

  task automatic test_mid_drop;
    run(4'd2, 32'h1, 32'h0000_003E, 32'h0, 32'h0, 14);
    n_tests++; if (obs_in !== 32'h0000_003E) begin n_fail++; $display("FAIL drop_inflag: got %h want %h", obs_in, 32'h3E); end
    n_tests++; if (obs_done !== 32'h0000_0080) begin n_fail++; $display("FAIL drop_done: got %h want %h", obs_done, 32'h80); end
    n_tests++; if (obs_out !== 32'h0) begin n_fail++; $display("FAIL drop_outflag: got %h want 0", obs_out); end
    n_tests++; if ({seen_id, seen_err} !== {4'd2, 2'b01}) begin n_fail++; $display("FAIL drop_id_err: got %h/%b want 2/01", seen_id, seen_err); end
  endtask

  task automatic test_missing_ack;
    run(4'd7, 32'h1, 32'hFFFF_FFFF, 32'h0, 32'h0, 18);
    n_tests++; if (obs_done !== 32'h0001_0000) begin n_fail++; $display("FAIL noack_done: got %h want %h", obs_done, 32'h10000); end
    n_tests++; if ({seen_id, seen_err} !== {4'd7, 2'b10}) begin n_fail++; $display("FAIL noack_id_err: got %h/%b want 7/10", seen_id, seen_err); end
  endtask

  task automatic test_ack_in_done;
    run(4'd8, 32'h1, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0, 18);
    n_tests++; if ({seen_id, seen_err} !== {4'd8, 2'b00}) begin n_fail++; $display("FAIL ackdone_id_err: got %h/%b want 8/00", seen_id, seen_err); end
  endtask

  task automatic test_ignored_issue;
    run(4'd1, 32'h0000_0009, 32'hFFFF_FFFF, 32'h0000_8000, 32'h0, 18);
    n_tests++; if (ndone !== 1) begin n_fail++; $display("FAIL ign_ndone: got %0d want 1", ndone); end
    n_tests++; if (obs_out !== 32'h0000_F000) begin n_fail++; $display("FAIL ign_outflag: got %h want %h", obs_out, 32'hF000); end
    n_tests++; if ({seen_id, seen_err} !== {4'd1, 2'b00}) begin n_fail++; $display("FAIL ign_id_err: got %h/%b want 1/00", seen_id, seen_err); end
  endtask

  task automatic test_back_to_back;
    run(4'd4, 32'h1, 32'hFFFF_FFFF, 32'h0000_8000, 32'h0, 17);
    n_tests++; if ({seen_id, seen_err} !== {4'd4, 2'b00}) begin n_fail++; $display("FAIL b2b_first: got %h/%b want 4/00", seen_id, seen_err); end
    run(4'd6, 32'h1, 32'hFFFF_FFFF, 32'h0000_8000, 32'h0, 18);
    n_tests++; if (obs_ready !== 32'h0002_0001) begin n_fail++; $display("FAIL b2b_ready: got %h want %h", obs_ready, 32'h20001); end
    n_tests++; if (obs_in !== 32'h0000_01FE) begin n_fail++; $display("FAIL b2b_inflag: got %h want %h", obs_in, 32'h1FE); end
    n_tests++; if (obs_done !== 32'h0001_0000) begin n_fail++; $display("FAIL b2b_done: got %h want %h", obs_done, 32'h10000); end
    n_tests++; if ({seen_id, seen_err} !== {4'd6, 2'b00}) begin n_fail++; $display("FAIL b2b_second: got %h/%b want 6/00", seen_id, seen_err); end
  endtask

  task automatic test_reset_in_drive;
    run(4'hA, 32'h1, 32'hFFFF_FFFF, 32'h0000_8000, 32'h0000_6000, 18);
    n_tests++; if (obs_out !== 32'h0000_1000) begin n_fail++; $display("FAIL rstdrv_outflag: got %h want %h", obs_out, 32'h1000); end
    n_tests++; if (ndone !== 0) begin n_fail++; $display("FAIL rstdrv_ndone: got %0d want 0", ndone); end
    n_tests++; if (obs_ready !== 32'h0003_E001) begin n_fail++; $display("FAIL rstdrv_ready: got %h want %h", obs_ready, 32'h3E001); end
    run(4'hB, 32'h1, 32'hFFFF_FFFF, 32'h0000_8000, 32'h0, 18);
    n_tests++; if (obs_out !== 32'h0000_F000) begin n_fail++; $display("FAIL rstdrv_fresh_out: got %h want %h", obs_out, 32'hF000); end
    n_tests++; if (obs_done !== 32'h0001_0000) begin n_fail++; $display("FAIL rstdrv_fresh_done: got %h want %h", obs_done, 32'h10000); end
    n_tests++; if ({seen_id, seen_err} !== {4'hB, 2'b00}) begin n_fail++; $display("FAIL rstdrv_fresh_id_err: got %h/%b want b/00", seen_id, seen_err); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_late_start();
    test_missed_start();
    test_mid_drop();
    test_missing_ack();
    test_ack_in_done();
    test_ignored_issue();
    test_back_to_back();
    test_reset_in_drive();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
